// File: rtl/tone_event_encoder.sv
// ============================================================================
// tone_event_encoder : N-of-WIN vote with hysteresis on two tone-hit flags,
//                      one-byte change events over a one-entry valid/ready hold.
// Revision 1.0
// ============================================================================
`default_nettype none

module tone_event_encoder #(
  parameter int WIN    = 8,
  parameter int ON_TH  = 6,
  parameter int OFF_TH = 2
) (
  input  logic       clk,
  input  logic       rst_in,
  input  logic [7:0] value,
  input  logic       stb,
  output logic       tone3,
  output logic       tone4,
  output logic [7:0] evt_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic       overflow,
  output logic [7:0] drop_cnt
);

  localparam int CW = $clog2(WIN + 1);

  logic [WIN-1:0] h3;
  logic [WIN-1:0] h4;
  logic           stb_d;
  logic [3:0]     win_cnt;

  logic [CW-1:0]  c3;
  logic [CW-1:0]  c4;
  logic           t3_n;
  logic           t4_n;
  logic           new_evt;
  logic [3:0]     dur;
  logic [7:0]     evt_next;
  logic           unused_bits;

  assign unused_bits = ^{value[7:5], value[2:0]};

  always_comb begin
    c3 = '0;
    c4 = '0;
    for (int i = 0; i < WIN; i++) begin
      c3 = c3 + CW'(h3[i]);
      c4 = c4 + CW'(h4[i]);
    end
  end

  // Hysteresis: the on and off thresholds only apply from the opposite state.
  always_comb begin
    t3_n = tone3;
    t4_n = tone4;
    if (!tone3 && c3 >= CW'(ON_TH))       t3_n = 1'b1;
    else if (tone3 && c3 <= CW'(OFF_TH))  t3_n = 1'b0;
    if (!tone4 && c4 >= CW'(ON_TH))       t4_n = 1'b1;
    else if (tone4 && c4 <= CW'(OFF_TH))  t4_n = 1'b0;
  end

  assign new_evt  = stb_d && ((t3_n != tone3) || (t4_n != tone4));
  assign dur      = (win_cnt == 4'hF) ? 4'hF : win_cnt + 4'd1;
  assign evt_next = {2'b10, t4_n, t3_n, dur};

  always_ff @(posedge clk) begin
    if (rst_in) begin
      h3        <= '0;
      h4        <= '0;
      stb_d     <= 1'b0;
      win_cnt   <= 4'd0;
      tone3     <= 1'b0;
      tone4     <= 1'b0;
      evt_data  <= 8'd0;
      evt_valid <= 1'b0;
      overflow  <= 1'b0;
      drop_cnt  <= 8'd0;
    end else begin
      stb_d <= stb;
      if (stb) begin
        h3 <= {h3[WIN-2:0], value[3]};
        h4 <= {h4[WIN-2:0], value[4]};
      end
      if (stb_d) begin
        tone3   <= t3_n;
        tone4   <= t4_n;
        win_cnt <= new_evt ? 4'd0 : dur;
      end
      // A consumer handshake on the same edge frees the slot for the new event.
      if (new_evt) begin
        if (!evt_valid || evt_ready) begin
          evt_data  <= evt_next;
          evt_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
          if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
